// File: rtl/iigs_mem_ctrl.sv
// rtl/iigs_mem_ctrl.sv - IIGS bus memory controller: region decode, clock-enable pacing, video shadowing
module iigs_mem_ctrl #(
    parameter int RAMSIZE  = 16,
    parameter int FAST_DIV = 8,
    parameter int SLOW_DIV = 28
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic [7:0]  cpu_bank,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ready,
    input  logic [3:0]  shadow_mask,
    output logic        fast_tick,
    output logic        slow_tick,
    output logic        rom_ce,
    output logic [16:0] rom_addr,
    input  logic [7:0]  rom_q,
    output logic        fram_ce,
    output logic        fram_we,
    output logic [22:0] fram_addr,
    input  logic [7:0]  fram_q,
    output logic        sram_ce,
    output logic        sram_we,
    output logic [16:0] sram_addr,
    input  logic [7:0]  sram_q,
    output logic [7:0]  mem_din
);
    localparam int FW = $clog2(FAST_DIV);
    localparam int SW = $clog2(SLOW_DIV);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [7:0]    bank_q, bank_d;
    logic [15:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [7:0]    din_q, din_d;
    logic          rom_q_f, rom_d_f;
    logic          fast_q, fast_d;
    logic          slow_q, slow_d;
    logic          shadow_q, shadow_d;
    logic [7:0]    dout_q, dout_d;

    logic dec_rom, dec_fast, dec_slow, dec_shadow, in_rng, need_tick, issue;

    assign fast_tick = (fcnt_q == FW'(FAST_DIV - 1));
    assign slow_tick = (scnt_q == SW'(SLOW_DIV - 1));

    always_comb begin
        fcnt_d = fast_tick ? '0 : fcnt_q + FW'(1);
        scnt_d = slow_tick ? '0 : scnt_q + SW'(1);
    end

    // Region decode of the live bus request; only consumed at acceptance.
    always_comb begin
        dec_rom    = (cpu_bank == 8'hFE) || (cpu_bank == 8'hFF) ||
                     ((cpu_bank == 8'h00) && (cpu_addr >= 16'hC100));
        dec_fast   = !dec_rom && (cpu_bank < 8'(RAMSIZE));
        dec_slow   = !dec_rom && !dec_fast && (cpu_bank[7:1] == 7'h70);
        in_rng     = (shadow_mask[0] && cpu_addr >= 16'h0400 && cpu_addr <= 16'h07FF) ||
                     (shadow_mask[1] && cpu_addr >= 16'h0800 && cpu_addr <= 16'h0BFF) ||
                     (shadow_mask[2] && cpu_addr >= 16'h2000 && cpu_addr <= 16'h3FFF) ||
                     (shadow_mask[3] && cpu_addr >= 16'h4000 && cpu_addr <= 16'h5FFF);
        dec_shadow = dec_fast && cpu_we && (cpu_bank[7:1] == 7'h00) && in_rng;
    end

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        we_d      = we_q;
        din_d     = din_q;
        rom_d_f   = rom_q_f;
        fast_d    = fast_q;
        slow_d    = slow_q;
        shadow_d  = shadow_q;
        dout_d    = dout_q;
        // Shadowed writes must land in slow RAM too, so they pace to the slow clock.
        need_tick = (slow_q || shadow_q) ? slow_tick : fast_tick;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    state_d  = S_WAIT;
                    bank_d   = cpu_bank;
                    addr_d   = cpu_addr;
                    we_d     = cpu_we;
                    din_d    = cpu_din;
                    rom_d_f  = dec_rom;
                    fast_d   = dec_fast;
                    slow_d   = dec_slow;
                    shadow_d = dec_shadow;
                end
            end
            S_WAIT: begin
                if (need_tick) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_CAPTURE;
            S_CAPTURE: begin
                state_d = S_ACK;
                if (!we_q) begin
                    if (rom_q_f) begin
                        dout_d = rom_q;
                    end else if (fast_q) begin
                        dout_d = fram_q;
                    end else if (slow_q) begin
                        dout_d = sram_q;
                    end else begin
                        dout_d = 8'hFF;
                    end
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            fcnt_q   <= '0;
            scnt_q   <= '0;
            bank_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            din_q    <= '0;
            rom_q_f  <= 1'b0;
            fast_q   <= 1'b0;
            slow_q   <= 1'b0;
            shadow_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            scnt_q   <= scnt_d;
            bank_q   <= bank_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            din_q    <= din_d;
            rom_q_f  <= rom_d_f;
            fast_q   <= fast_d;
            slow_q   <= slow_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
        end
    end

    // Strobes decode straight from state so reset kills an in-flight strobe at once.
    assign issue     = (state_q == S_ISSUE);
    assign rom_ce    = issue && rom_q_f && !we_q;
    assign fram_ce   = issue && fast_q;
    assign fram_we   = fram_ce && we_q;
    assign sram_ce   = issue && (slow_q || shadow_q);
    assign sram_we   = sram_ce && we_q;
    assign rom_addr  = {(bank_q == 8'hFF), addr_q};
    assign fram_addr = {bank_q[6:0], addr_q};
    assign sram_addr = {bank_q[0], addr_q};
    assign mem_din   = din_q;
    assign cpu_dout  = dout_q;
    assign cpu_ready = (state_q == S_ACK);
endmodule
